// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer and status controller for an asynchronous FIFO.
// Synchronizes the write Gray pointer and produces the registered read pointer, RAM address and flags.
module fifo_rd_ptr_ctrl #(
    parameter int unsigned D_WIDTH     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AE_LEVEL    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [D_WIDTH:0]   wptr_gray,
    output logic [D_WIDTH:0]   rptr_gray,
    output logic [D_WIDTH-1:0] raddr,
    output logic               empty,
    output logic               almost_empty,
    output logic [D_WIDTH:0]   rd_count,
    output logic               rd_valid,
    output logic               underflow
);

    localparam int unsigned PW = D_WIDTH + 1;
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
    logic [PW-1:0] wq;
    logic [PW-1:0] wbin_c;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_nxt_c;
    logic [PW-1:0] rgray_nxt_c;
    logic [PW-1:0] count_nxt_c;
    logic          rd_accept_c;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    // Plain flop chain on the asynchronous write pointer; nothing between stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray};
        end
    end

    assign wq = sync_q[SYNC_STAGES-1];

    // Next-state pointer and fill-level computation.
    always_comb begin
        wbin_c      = gray2bin(wq);
        rd_accept_c = rd_en & ~empty;
        rbin_nxt_c  = rbin + PW'(rd_accept_c);
        rgray_nxt_c = rbin_nxt_c ^ (rbin_nxt_c >> 1);
        count_nxt_c = wbin_c - rbin_nxt_c;
    end

    // Registered pointer and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            rd_valid     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rbin         <= rbin_nxt_c;
            rptr_gray    <= rgray_nxt_c;
            empty        <= (rgray_nxt_c == wq);
            almost_empty <= (count_nxt_c <= AE_THR);
            rd_count     <= count_nxt_c;
            rd_valid     <= rd_accept_c;
            underflow    <= rd_en & empty;
        end
    end

    assign raddr = rbin[D_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Bench for fifo_rd_ptr_ctrl: directed scenarios plus random traffic against an
// absolute-pointer reference model in which writes become visible SYNC_STAGES edges late.
module tb_fifo_rd_ptr_ctrl;

    localparam int unsigned DW   = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned AE   = 2;
    localparam int          DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          rd_en;
    logic [DW:0]   wptr_gray;
    logic [DW:0]   rptr_gray;
    logic [DW-1:0] raddr;
    logic          empty;
    logic          almost_empty;
    logic [DW:0]   rd_count;
    logic          rd_valid;
    logic          underflow;

    fifo_rd_ptr_ctrl #(
        .D_WIDTH    (DW),
        .SYNC_STAGES(SYNC),
        .AE_LEVEL   (AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .wptr_gray   (wptr_gray),
        .rptr_gray   (rptr_gray),
        .raddr       (raddr),
        .empty       (empty),
        .almost_empty(almost_empty),
        .rd_count    (rd_count),
        .rd_valid    (rd_valid),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute (unwrapped) pointers, writes visible after SYNC edges.
    int wb;
    int m_rptr;
    int m_count;
    bit m_empty;
    bit m_ae;
    bit m_valid;
    bit m_under;
    int vis_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW:0] to_gray(input int b);
        logic [DW:0] x;
        x = (DW+1)'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic model_reset();
        wb      = 0;
        m_rptr  = 0;
        m_count = 0;
        m_empty = 1'b1;
        m_ae    = 1'b1;
        m_valid = 1'b0;
        m_under = 1'b0;
        vis_q.delete();
        for (int i = 0; i < int'(SYNC); i++) vis_q.push_back(0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_ae"}, int'(almost_empty), 1);
        chk({tag, "_count"}, int'(rd_count), 0);
        chk({tag, "_rgray"}, int'(rptr_gray), 0);
        chk({tag, "_raddr"}, int'(raddr), 0);
        chk({tag, "_valid"}, int'(rd_valid), 0);
        chk({tag, "_under"}, int'(underflow), 0);
    endtask

    task automatic check_outputs();
        chk("rptr_gray", int'(rptr_gray), int'(to_gray(m_rptr)));
        chk("raddr", int'(raddr), m_rptr % DEPTH);
        chk("empty", int'(empty), int'(m_empty));
        chk("almost_empty", int'(almost_empty), int'(m_ae));
        chk("rd_count", int'(rd_count), m_count);
        chk("rd_valid", int'(rd_valid), int'(m_valid));
        chk("underflow", int'(underflow), int'(m_under));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit ren, input int wnext);
        int vis;
        bit acc;
        rd_en     = ren;
        wb        = wnext;
        wptr_gray = to_gray(wnext);
        @(posedge clk);
        vis = vis_q.pop_front();
        vis_q.push_back(wnext);
        acc     = ren && !m_empty;
        m_under = ren && m_empty;
        m_valid = acc;
        m_rptr  = m_rptr + int'(acc);
        m_count = vis - m_rptr;
        m_empty = (m_count == 0);
        m_ae    = (m_count <= int'(AE));
        #1;
        check_outputs();
    endtask

    initial begin
        int nvalid;
        int nunder;
        int wrap_seen;
        logic [DW:0] prev_g;
        logic [DW-1:0] prev_a;
        int guard;

        // Scenario 1: asynchronous reset with arbitrary inputs.
        rst_n     = 1'b1;
        rd_en     = 1'b1;
        wptr_gray = (DW+1)'($urandom);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst_async");
        repeat (3) begin
            @(posedge clk);
            wptr_gray = (DW+1)'($urandom);
        end
        #1 check_reset_vals("rst_held");
        rd_en     = 1'b0;
        wptr_gray = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Scenario 2: single write reaches empty after two synchronizer edges.
        step(0, 1);
        chk("s2_empty_k", int'(empty), 1);
        step(0, 1);
        chk("s2_empty_k1", int'(empty), 1);
        step(0, 1);
        chk("s2_empty_k2", int'(empty), 0);
        chk("s2_count_k2", int'(rd_count), 1);

        // Scenario 3: full FIFO, then drain with one extra request.
        repeat (3) step(0, 16);
        chk("s3_full_count", int'(rd_count), 16);
        chk("s3_full_ae", int'(almost_empty), 0);
        nvalid = 0;
        nunder = 0;
        for (int i = 0; i < 17; i++) begin
            step(1, 16);
            nvalid += int'(rd_valid);
            nunder += int'(underflow);
        end
        chk("s3_valid_cycles", nvalid, 16);
        chk("s3_under_pulses", nunder, 1);
        chk("s3_final_gray", int'(rptr_gray), 24);
        step(0, 16);
        chk("s3_under_clears", int'(underflow), 0);

        // Scenarios 4/5: streaming reads past pointer wrap, one Gray bit per read.
        wrap_seen = 0;
        for (int i = 0; i < 30; i++) begin
            prev_g = rptr_gray;
            prev_a = raddr;
            step(1, wb + 1);
            chk("s4_gray_step", $countones(prev_g ^ rptr_gray), int'(m_valid));
            if (prev_g == 5'b10000 && rptr_gray == 5'b00000 && prev_a == 4'd15 && raddr == 4'd0)
                wrap_seen = 1;
        end
        chk("s4_wrap_seen", wrap_seen, 1);

        // Random traffic within the FIFO's capacity.
        for (int i = 0; i < 400; i++) begin
            int nw;
            nw = wb;
            if ($urandom_range(0, 1) == 1 && wb < m_rptr + DEPTH) nw = wb + 1;
            step(1'($urandom_range(0, 1)), nw);
        end

        // Scenario 6: bring fill level to 5, then reset mid-burst.
        guard = 0;
        while ((wb - m_rptr) != 5 && guard < 100) begin
            if ((wb - m_rptr) < 5) step(0, wb + 1);
            else step(1, wb);
            guard++;
        end
        repeat (SYNC + 1) step(0, wb);
        chk("s6_count5", int'(rd_count), 5);
        rd_en = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("s6_rst");
        wptr_gray = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("s6_rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0);
        chk("s6_no_accept", int'(rd_valid), 0);
        step(1, 0);
        chk("s6_no_move", int'(raddr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
